// File: rtl/keccak_theta_apply.sv
// Keccak theta-apply stage: latches the five theta D words, then XORs each
// streamed row of lane slices with its column's D word behind a one-deep output register.
module keccak_theta_apply #(
  parameter int W    = 32,
  parameter int NROW = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_aes_or_keccak,
  input  logic           i_start,
  input  logic           i_clear,
  input  logic [5*W-1:0] i_D,
  input  logic           i_row_valid,
  output logic           o_row_ready,
  input  logic [5*W-1:0] i_row_data,
  output logic           o_row_valid,
  input  logic           i_out_ready,
  output logic [5*W-1:0] o_row_data,
  output logic [2:0]     o_row_idx,
  output logic           o_busy,
  output logic           o_done
);

  localparam int CW = (NROW > 1) ? $clog2(NROW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [5*W-1:0] d_q;
  logic [5*W-1:0] row_xor;
  logic [CW-1:0]  row_cnt;
  logic           accept, consume, last_row, start_ok;

  assign start_ok = (state == IDLE) && i_start && !i_aes_or_keccak;
  assign accept   = (state == RUN) && i_row_valid && o_row_ready;
  assign consume  = o_row_valid && i_out_ready;
  assign last_row = (row_cnt == CW'(NROW - 1));

  // Lane x of the row meets D word x; columns never mix in this stage.
  for (genvar x = 0; x < 5; x++) begin : g_lane
    assign row_xor[x*W +: W] = i_row_data[x*W +: W] ^ d_q[x*W +: W];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_ok)            state_nxt = RUN;
        RUN:     if (accept && last_row)  state_nxt = DRAIN;
        DRAIN:   if (consume)             state_nxt = IDLE;
        default:                          state_nxt = IDLE;
      endcase
    end
  end

  // Ready only looks at state and the output register, never at i_row_valid.
  always_comb begin
    o_busy      = (state != IDLE);
    o_row_ready = 1'b0;
    if (state == RUN) o_row_ready = !o_row_valid || i_out_ready;
  end

  // NOTE: the data registers are reset too, so outputs read as zero during and
  // right after reset rather than holding stale lane data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d_q         <= '0;
      row_cnt     <= '0;
      o_row_data  <= '0;
      o_row_idx   <= '0;
      o_row_valid <= 1'b0;
      o_done      <= 1'b0;
    end else if (i_clear) begin
      // Abort drops the pending row but keeps D_q and the last data word.
      row_cnt     <= '0;
      o_row_valid <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= (state == DRAIN) && consume;
      if (start_ok) begin
        d_q     <= i_D;
        row_cnt <= '0;
      end
      if (accept) begin
        o_row_data  <= row_xor;
        o_row_idx   <= 3'(row_cnt);
        o_row_valid <= 1'b1;
        row_cnt     <= last_row ? '0 : row_cnt + CW'(1);
      end else if (consume) begin
        o_row_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/keccak_theta_apply.md
Name: keccak_theta_apply

Overview:
- Sequential Keccak theta-apply stage, directly downstream of the unified XOR section in the AES/Keccak datapath.
- Latches the five 32-bit theta D words produced by that section, then streams the 5x5 lane-slice state row by row.
- Each lane of a row is XORed with its column's D word and forwarded to the next stage over a valid/ready handshake.
- Idle whenever the datapath is in AES mode.

Parameters:
W, 32, lane-slice width in bits (one half of a 64-bit Keccak lane)
NROW, 5, rows per state; the row counter is clog2(NROW) bits wide

Ports:
i_clk  input  1  single clock, all state on its rising edge
i_rst_n  input  1  asynchronous active-low reset
i_aes_or_keccak  input  1  1 = AES mode (block ignores i_start), 0 = Keccak
i_start  input  1  one-cycle pulse; latch i_D and begin a pass
i_clear  input  1  synchronous abort; return to IDLE, drop any pending output
i_D  input  5xW  theta D words, index x = column 0..4
i_row_valid  input  1  upstream row valid
o_row_ready  output  1  stage accepts a row this cycle
i_row_data  input  5xW  row lanes, index x = column 0..4
o_row_valid  output  1  output row valid
i_out_ready  input  1  downstream accepts the output row
o_row_data  output  5xW  o_row_data[x] = i_row_data[x] ^ D_q[x]
o_row_idx  output  3  row index y (0..4) of o_row_data
o_busy  output  1  high in RUN or DRAIN
o_done  output  1  one-cycle pulse when the pass completes

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=IDLE. D_q, row_cnt, o_row_data, o_row_idx = 0. o_row_valid, o_busy, o_done = 0.
- States: IDLE, RUN, DRAIN. o_busy = (state != IDLE).
- IDLE:
  - o_row_ready=0.
  - i_start && !i_aes_or_keccak: D_q <= i_D, row_cnt <= 0, go to RUN.
  - i_start with i_aes_or_keccak=1: ignored.
- RUN:
  - o_row_ready = !o_row_valid || i_out_ready (single output register, full throughput).
  - Accept = i_row_valid && o_row_ready. On accept:
    - o_row_data <= i_row_data ^ D_q, lane-wise.
    - o_row_idx <= row_cnt; o_row_valid <= 1; row_cnt++.
  - Accept with row_cnt==NROW-1: go to DRAIN; row_cnt wraps to 0.
- Output register:
  - o_row_valid && i_out_ready with no accept in the same cycle: o_row_valid <= 0.
  - Simultaneous consume and accept: o_row_valid stays 1 and the data is replaced.
  - o_row_data and o_row_idx hold stable while o_row_valid && !i_out_ready.
- DRAIN:
  - o_row_ready=0.
  - Final output handshake (o_row_valid && i_out_ready): next cycle o_done=1, o_row_valid=0, state=IDLE.
- Latency: 1 cycle from accept to o_row_valid. Best-case pass is 5 accept cycles, then done.
- i_start while o_busy=1: ignored; D_q unchanged.
- i_clear (any state, priority over everything except reset): next cycle state=IDLE, o_row_valid=0, row_cnt=0, o_done=0. D_q retained.
- i_aes_or_keccak changing mid-pass: no effect; the pass completes. Only the start qualification uses it.
- Reset mid-pass: immediate return to reset values; no o_done.
- No combinational path from i_row_data to o_row_data. o_row_ready depends combinationally only on o_row_valid, i_out_ready and state.

Test Plan:
- Basic pass: D={1,2,4,8,16}, rows y=0..4 all lanes 0xFFFFFFFF, i_out_ready=1 -> each output lanes {FFFFFFFE,FFFFFFFD,FFFFFFFB,FFFFFFF7,FFFFFFEF}, o_row_idx 0..4 on consecutive cycles, o_done exactly one cycle after the idx-4 handshake.
- Backpressure: i_out_ready=0 for 3 cycles after the first accept -> o_row_ready=0, row 0 output held stable with idx 0; on release, rows 1..4 flow with no loss or duplication.
- AES mode: i_aes_or_keccak=1 with i_start -> o_busy stays 0, o_row_ready 0, no outputs, no o_done.
- Start while busy: second i_start with D=all 0xA5A5A5A5 during row 2 -> rows 3,4 still XOR the original D; exactly one o_done.
- Clear mid-pass: i_clear after row 2 accepted -> next cycle IDLE, o_row_valid=0, no o_done; a new i_start restarts at o_row_idx=0.
- Async reset mid-pass: i_rst_n low between clock edges during RUN -> outputs zero immediately; after release, IDLE and o_busy=0.
